// File: rtl/bt656_stream_decoder.sv
// bt656_stream_decoder: BT.656 TRS lock, F/V/H decode and 4:2:2 pair demux; optional XY protection check under BT656_PROTECT_CHECK_EN
module bt656_stream_decoder #(
  parameter int ACTIVE_BYTES = 1440,
  parameter int LINE_BYTES   = 1716,
  parameter int LINE_W       = 10
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        Din,
  input  logic              DinValid,
  output logic [7:0]        Cb,
  output logic [7:0]        Y0,
  output logic [7:0]        Cr,
  output logic [7:0]        Y1,
  output logic              PairValid,
  output logic [8:0]        PairCount,
  output logic [LINE_W-1:0] LineCount,
  output logic              Field,
  output logic              VBlank,
  output logic              HBlank,
  output logic              SyncError,
  output logic [2:0]        State
);
  localparam int CW = $clog2(LINE_BYTES + 1);
  typedef enum logic [2:0] {S_SEARCH, S_FF, S_Z1, S_Z2, S_ACTIVE, S_BLANK} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_cb, r_y0, r_cr, r_ocb, r_oy0, r_ocr, r_oy1;
  logic [8:0] r_pc;
  logic [LINE_W-1:0] r_line;
  logic r_pv, r_se, r_field, r_vblank, r_hblank;
  logic w_err, w_acc, w_cap, w_tick, w_ff, w_zero, w_pbad;
  assign w_ff = Din == 8'hFF;
  assign w_zero = Din == 8'h00;
`ifdef BT656_PROTECT_CHECK_EN
  assign w_pbad = Din[3:0] != {Din[5] ^ Din[4], Din[6] ^ Din[4], Din[6] ^ Din[5], Din[6] ^ Din[5] ^ Din[4]};
`else
  assign w_pbad = 1'b0;
`endif
  // state register
  always_ff @(posedge Clock)
    r_state <= Reset ? S_SEARCH : w_next;
  // next state and per-byte control; nothing moves unless DinValid
  always_comb begin
    w_next = r_state;
    w_err = 1'b0;
    w_acc = 1'b0;
    w_cap = 1'b0;
    w_tick = 1'b0;
    if (DinValid)
      case (r_state)
        S_SEARCH: w_next = w_ff ? S_FF : S_SEARCH;
        S_FF:     w_next = w_ff ? S_FF : w_zero ? S_Z1 : S_SEARCH;
        S_Z1:     w_next = w_ff ? S_FF : w_zero ? S_Z2 : S_SEARCH;
        S_Z2: begin
          w_err = !Din[7] || w_pbad;
          w_acc = !w_err;
          w_next = w_err ? S_SEARCH : (Din[4] || Din[5]) ? S_BLANK : S_ACTIVE;
        end
        S_ACTIVE:
          if (r_cnt == CW'(ACTIVE_BYTES)) begin
            w_err = !w_ff;
            w_next = w_ff ? S_FF : S_SEARCH;
          end else begin
            w_err = w_ff;
            w_cap = !w_ff;
            w_next = w_ff ? S_FF : S_ACTIVE;
          end
        S_BLANK: begin
          w_err = !w_ff && r_cnt == CW'(LINE_BYTES - 1);
          w_tick = !w_ff && !w_err;
          w_next = w_ff ? S_FF : w_err ? S_SEARCH : S_BLANK;
        end
        default: w_next = S_SEARCH;
      endcase
  end
  // flags, counters and pair capture; outputs only change when a whole pair lands
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt <= '0;
      r_cb <= '0;
      r_y0 <= '0;
      r_cr <= '0;
      r_ocb <= '0;
      r_oy0 <= '0;
      r_ocr <= '0;
      r_oy1 <= '0;
      r_pc <= '0;
      r_line <= '0;
      r_pv <= 1'b0;
      r_se <= 1'b0;
      r_field <= 1'b0;
      r_vblank <= 1'b1;
      r_hblank <= 1'b1;
    end else begin
      r_pv <= w_cap && r_cnt[1:0] == 2'd3;
      r_se <= w_err;
      if (w_acc) begin
        r_field <= Din[6];
        r_vblank <= Din[5];
        r_hblank <= Din[4];
        r_cnt <= '0;
        if (Din[4])
          r_line <= (Din[6] != r_field) ? '0 : (&r_line) ? r_line : r_line + 1'b1;
        else
          r_pc <= '0;
      end
      if (w_tick)
        r_cnt <= r_cnt + 1'b1;
      if (w_cap) begin
        r_cnt <= r_cnt + 1'b1;
        r_cb <= r_cnt[1:0] == 2'd0 ? Din : r_cb;
        r_y0 <= r_cnt[1:0] == 2'd1 ? Din : r_y0;
        r_cr <= r_cnt[1:0] == 2'd2 ? Din : r_cr;
        if (r_cnt[1:0] == 2'd0 && r_cnt != '0)
          r_pc <= r_pc + 1'b1;
        if (r_cnt[1:0] == 2'd3) begin
          r_ocb <= r_cb;
          r_oy0 <= r_y0;
          r_ocr <= r_cr;
          r_oy1 <= Din;
        end
      end
    end
  end
  assign Cb = r_ocb;
  assign Y0 = r_oy0;
  assign Cr = r_ocr;
  assign Y1 = r_oy1;
  assign PairValid = r_pv;
  assign PairCount = r_pc;
  assign LineCount = r_line;
  assign Field = r_field;
  assign VBlank = r_vblank;
  assign HBlank = r_hblank;
  assign SyncError = r_se;
  assign State = r_state;
endmodule
